// File: rtl/uart_loader_ctrl_if.sv
// Purpose: bundles the UART byte handshake, memory write ports and run control of the loader.
// Latency: none, signal container only.
// Backpressure: tx_ready stalls the status byte; the rx side has none (edge-qualified strobe).
interface uart_loader_ctrl_if;
    logic        rx_rd;
    logic [7:0]  rx_dout;
    logic        tx_ready;
    logic        tx_wr;
    logic [31:0] tx_din;
    logic [31:0] insn_addr;
    logic [31:0] insn_din;
    logic        insn_we;
    logic [31:0] data_addr;
    logic [31:0] data_din;
    logic        data_we;
    logic        run;
    logic        busy;

    // Loader side: consumes rx bytes and tx_ready, drives everything else.
    modport slave (
        input  rx_rd, rx_dout, tx_ready,
        output tx_wr, tx_din, insn_addr, insn_din, insn_we,
               data_addr, data_din, data_we, run, busy
    );

    // Environment side: UART pair and core.
    modport master (
        output rx_rd, rx_dout, tx_ready,
        input  tx_wr, tx_din, insn_addr, insn_din, insn_we,
               data_addr, data_din, data_we, run, busy
    );
endinterface

// File: rtl/uart_loader_ctrl.sv
// Purpose: parses framed UART commands into instruction/data memory writes and core run/halt control.
// Latency: a memory write appears the cycle after the 4th byte of a word; run rises RUN_DELAY cycles after RUN.
// Backpressure: the status byte waits in ACK until tx_ready; bytes arriving in ACK/RUNWAIT are dropped.
module uart_loader_ctrl #(
    parameter int RUN_DELAY      = 100,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic               clk,
    input  logic               reset,
    uart_loader_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_RUNWAIT = 3'd4;
    localparam logic [2:0] S_ACK     = 3'd5;

    logic [2:0]  r_state;
    logic        r_rx_rd;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [15:0] r_len;
    logic [1:0]  r_cnt;
    logic [31:0] r_buf;
    logic [15:0] r_widx;
    logic        r_done;
    logic [31:0] r_tmo;
    logic [31:0] r_delay;
    logic [7:0]  r_status;
    logic        r_tx_wr;
    logic [31:0] r_tx_din;
    logic [31:0] r_insn_addr, r_insn_din, r_data_addr, r_data_din;
    logic        r_insn_we, r_data_we, r_run;

    logic        w_acc;
    logic [7:0]  w_byte;
    logic [31:0] w_word;
    logic [31:0] w_waddr;
    logic        w_tmo_hit;

    assign w_acc     = bus.rx_rd & ~r_rx_rd;
    assign w_byte    = bus.rx_dout;
    assign w_word    = {w_byte, r_buf[31:8]};
    assign w_waddr   = r_addr + {14'd0, r_widx, 2'b00};
    assign w_tmo_hit = (r_tmo == 32'(TIMEOUT_CYCLES - 1));

    assign bus.tx_wr     = r_tx_wr;
    assign bus.tx_din    = r_tx_din;
    assign bus.insn_addr = r_insn_addr;
    assign bus.insn_din  = r_insn_din;
    assign bus.insn_we   = r_insn_we;
    assign bus.data_addr = r_data_addr;
    assign bus.data_din  = r_data_din;
    assign bus.data_we   = r_data_we;
    assign bus.run       = r_run;
    assign bus.busy      = (r_state != S_IDLE);

    // Remember last rx_rd level so a long strobe yields a single byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rx_rd <= 1'b0;
        else       r_rx_rd <= bus.rx_rd;
    end

    // Packet parser, write generator, run sequencer and status return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'd0;
            r_addr      <= 32'd0;
            r_len       <= 16'd0;
            r_cnt       <= 2'd0;
            r_buf       <= 32'd0;
            r_widx      <= 16'd0;
            r_done      <= 1'b0;
            r_tmo       <= 32'd0;
            r_delay     <= 32'd0;
            r_status    <= 8'd0;
            r_tx_wr     <= 1'b0;
            r_tx_din    <= 32'd0;
            r_insn_addr <= 32'd0;
            r_insn_din  <= 32'd0;
            r_insn_we   <= 1'b0;
            r_data_addr <= 32'd0;
            r_data_din  <= 32'd0;
            r_data_we   <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_insn_we <= 1'b0;
            r_data_we <= 1'b0;
            r_tx_wr   <= 1'b0;
            case (r_state)
                S_IDLE: if (w_acc) begin
                    case (w_byte)
                        8'h01, 8'h02: begin
                            r_cmd   <= w_byte;
                            r_run   <= 1'b0;
                            r_cnt   <= 2'd0;
                            r_tmo   <= 32'd0;
                            r_state <= S_ADDR;
                        end
                        8'h03: begin
                            r_delay <= 32'd0;
                            r_state <= S_RUNWAIT;
                        end
                        8'h04: begin
                            r_run    <= 1'b0;
                            r_status <= 8'hA4;
                            r_state  <= S_ACK;
                        end
                        default: begin
                            r_status <= 8'hEE;
                            r_state  <= S_ACK;
                        end
                    endcase
                end
                S_ADDR: begin
                    if (w_acc) begin
                        r_tmo <= 32'd0;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            // Word-align the base; low address bits are discarded.
                            r_addr  <= {w_byte, r_addr[31:10], 2'b00};
                            r_cnt   <= 2'd0;
                            r_state <= S_LEN;
                        end else begin
                            r_addr <= {w_byte, r_addr[31:8]};
                        end
                    end else if (w_tmo_hit) begin
                        r_status <= 8'hEE;
                        r_state  <= S_ACK;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                S_LEN: begin
                    if (w_acc) begin
                        r_tmo <= 32'd0;
                        r_len <= {w_byte, r_len[15:8]};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd1) begin
                            r_cnt <= 2'd0;
                            if ({w_byte, r_len[15:8]} == 16'd0) begin
                                r_status <= 8'hA0 | r_cmd;
                                r_state  <= S_ACK;
                            end else begin
                                r_widx  <= 16'd0;
                                r_done  <= 1'b0;
                                r_state <= S_PAYLOAD;
                            end
                        end
                    end else if (w_tmo_hit) begin
                        r_status <= 8'hEE;
                        r_state  <= S_ACK;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (r_done) begin
                        // One extra cycle so the last write strobe is seen inside PAYLOAD.
                        r_state <= S_ACK;
                    end else if (w_acc) begin
                        r_tmo <= 32'd0;
                        r_buf <= w_word;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_cmd == 8'h02) begin
                                r_data_we   <= 1'b1;
                                r_data_addr <= w_waddr;
                                r_data_din  <= w_word;
                            end else begin
                                r_insn_we   <= 1'b1;
                                r_insn_addr <= w_waddr;
                                r_insn_din  <= w_word;
                            end
                            r_widx <= r_widx + 16'd1;
                            if (r_widx == r_len - 16'd1) begin
                                r_done   <= 1'b1;
                                r_status <= 8'hA0 | r_cmd;
                            end
                        end
                    end else if (w_tmo_hit) begin
                        r_status <= 8'hEE;
                        r_state  <= S_ACK;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                S_RUNWAIT: begin
                    if (r_run) begin
                        r_status <= 8'hA3;
                        r_state  <= S_ACK;
                    end else if ((r_delay + 32'd1) >= 32'(RUN_DELAY)) begin
                        r_run    <= 1'b1;
                        r_status <= 8'hA3;
                        r_state  <= S_ACK;
                    end else begin
                        r_delay <= r_delay + 32'd1;
                    end
                end
                S_ACK: if (bus.tx_ready) begin
                    r_tx_wr  <= 1'b1;
                    r_tx_din <= {24'd0, r_status};
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Purpose: self-checking bench for uart_loader_ctrl with directed and random packets.
// Latency: n/a.
// Backpressure: exercises tx_ready stalls and long rx strobes.
module tb_uart_loader_ctrl;
    localparam int RUN_DELAY = 100;
    localparam int TIMEOUT   = 300;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_loader_ctrl_if bus();

    uart_loader_ctrl #(.RUN_DELAY(RUN_DELAY), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ia_q[$], id_q[$], da_q[$], dd_q[$];
    logic [7:0]  tx_q[$];
    int          tx_hi_bad = 0;
    logic [31:0] eia_q[$], eid_q[$], eda_q[$], edd_q[$];

    // Observe outputs just after each active edge.
    always @(posedge clk) begin
        #1;
        if (bus.insn_we) begin ia_q.push_back(bus.insn_addr); id_q.push_back(bus.insn_din); end
        if (bus.data_we) begin da_q.push_back(bus.data_addr); dd_q.push_back(bus.data_din); end
        if (bus.tx_wr) begin
            tx_q.push_back(bus.tx_din[7:0]);
            if (bus.tx_din[31:8] != 24'd0) tx_hi_bad++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete(); tx_q.delete();
        eia_q.delete(); eid_q.delete(); eda_q.delete(); edd_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_dout = b;
        bus.rx_rd   = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        bus.rx_rd = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    // Reference: decode a whole packet as a byte list into expected writes and status.
    task automatic model(input bq_t p, output logic [7:0] st);
        logic [7:0]  cmd;
        logic [31:0] base, word, a;
        int          len, nw;
        cmd = p[0];
        st  = 8'hEE;
        if (cmd == 8'h03) st = 8'hA3;
        else if (cmd == 8'h04) st = 8'hA4;
        else if ((cmd == 8'h01 || cmd == 8'h02) && p.size() >= 7) begin
            base = {p[4], p[3], p[2], p[1]} & 32'hFFFF_FFFC;
            len  = int'({p[6], p[5]});
            nw   = (p.size() - 7) / 4;
            for (int k = 0; k < nw && k < len; k++) begin
                word = {p[7+4*k+3], p[7+4*k+2], p[7+4*k+1], p[7+4*k]};
                a    = base + 32'(4 * k);
                if (cmd == 8'h01) begin eia_q.push_back(a); eid_q.push_back(word); end
                else              begin eda_q.push_back(a); edd_q.push_back(word); end
            end
            st = (p.size() - 7 >= len * 4) ? (8'hA0 | cmd) : 8'hEE;
        end
    endtask

    task automatic wait_ack(output logic [7:0] st, output bit ok);
        ok = 1'b0;
        st = 8'h00;
        for (int c = 0; c < TIMEOUT + 500; c++) begin
            if (tx_q.size() > 0) begin
                st = tx_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx_rd = 1'b0; bus.rx_dout = 8'h00; bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.tx_wr, bus.tx_din, bus.insn_addr, bus.insn_din, bus.insn_we, bus.data_addr,
             bus.data_din, bus.data_we, bus.run} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs expected all 0");
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_insn_load();
        bq_t p;
        logic [7:0] st; bit ok;
        p = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h78, 8'h56, 8'h34, 8'h12};
        clear_mon();
        send_pkt(p);
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hA1) begin n_fail++; $display("FAIL insn_ack: got %h (seen %0d) expected a1", st, ok); end
        n_checks++;
        if (ia_q.size() !== 2) begin n_fail++; $display("FAIL insn_count: got %0d expected 2", ia_q.size()); end
        else begin
            n_checks++;
            if (ia_q[0] !== 32'h100 || id_q[0] !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL insn_w0: got %h/%h expected 00000100/deadbeef", ia_q[0], id_q[0]);
            end
            n_checks++;
            if (ia_q[1] !== 32'h104 || id_q[1] !== 32'h12345678) begin
                n_fail++; $display("FAIL insn_w1: got %h/%h expected 00000104/12345678", ia_q[1], id_q[1]);
            end
        end
        n_checks++;
        if (da_q.size() !== 0) begin n_fail++; $display("FAIL insn_no_data: got %0d expected 0", da_q.size()); end
        n_checks++;
        if (tx_hi_bad !== 0) begin n_fail++; $display("FAIL tx_din_upper: got %0d nonzero expected 0", tx_hi_bad); end
    endtask

    task automatic test_data_load();
        bq_t p;
        logic [7:0] st; bit ok;
        p = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        clear_mon();
        send_pkt(p);
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hA2) begin n_fail++; $display("FAIL data_ack: got %h expected a2", st); end
        n_checks++;
        if (da_q.size() !== 1 || ia_q.size() !== 0) begin
            n_fail++; $display("FAIL data_count: got %0d/%0d expected 1/0", da_q.size(), ia_q.size());
        end else begin
            n_checks++;
            if (da_q[0] !== 32'h0 || dd_q[0] !== 32'h44332211) begin
                n_fail++; $display("FAIL data_w0: got %h/%h expected 00000000/44332211", da_q[0], dd_q[0]);
            end
        end
    endtask

    task automatic test_random_loads();
        bq_t p;
        logic [7:0] st, est; bit ok;
        logic [31:0] addr, w;
        int len;
        for (int it = 0; it < 8; it++) begin
            p.delete();
            clear_mon();
            p.push_back(8'($urandom_range(1, 2)));
            addr = (it == 0) ? 32'hFFFF_FFFA : $urandom;
            len  = (it == 0) ? 3 : $urandom_range(1, 4);
            for (int b = 0; b < 4; b++) p.push_back(addr[8*b +: 8]);
            p.push_back(8'(len)); p.push_back(8'h00);
            for (int k = 0; k < len; k++) begin
                w = $urandom;
                for (int b = 0; b < 4; b++) p.push_back(w[8*b +: 8]);
            end
            model(p, est);
            send_pkt(p);
            wait_ack(st, ok);
            n_checks++;
            if (!ok || st !== est) begin n_fail++; $display("FAIL rand_ack[%0d]: got %h expected %h", it, st, est); end
            n_checks++;
            if (ia_q.size() !== eia_q.size() || da_q.size() !== eda_q.size()) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: got %0d/%0d expected %0d/%0d", it, ia_q.size(), da_q.size(),
                         eia_q.size(), eda_q.size());
            end else begin
                foreach (eia_q[i]) begin
                    n_checks++;
                    if (ia_q[i] !== eia_q[i] || id_q[i] !== eid_q[i]) begin
                        n_fail++; $display("FAIL rand_insn[%0d.%0d]: got %h/%h expected %h/%h", it, i,
                                           ia_q[i], id_q[i], eia_q[i], eid_q[i]);
                    end
                end
                foreach (eda_q[i]) begin
                    n_checks++;
                    if (da_q[i] !== eda_q[i] || dd_q[i] !== edd_q[i]) begin
                        n_fail++; $display("FAIL rand_data[%0d.%0d]: got %h/%h expected %h/%h", it, i,
                                           da_q[i], dd_q[i], eda_q[i], edd_q[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_run_halt();
        logic [7:0] st; bit ok;
        int n;
        bq_t p;
        clear_mon();
        @(negedge clk);
        bus.rx_dout = 8'h03; bus.rx_rd = 1'b1;
        @(posedge clk);
        n = 0;
        for (int c = 0; c < RUN_DELAY + 20; c++) begin
            @(posedge clk); #1;
            n++;
            bus.rx_rd = 1'b0;
            if (bus.run) break;
        end
        n_checks++;
        if (n !== RUN_DELAY) begin n_fail++; $display("FAIL run_delay: got %0d cycles expected %0d", n, RUN_DELAY); end
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hA3) begin n_fail++; $display("FAIL run_ack: got %h expected a3", st); end
        send_byte(8'h03);
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hA3 || bus.run !== 1'b1) begin
            n_fail++; $display("FAIL run_again: got %h run=%b expected a3 run=1", st, bus.run);
        end
        @(negedge clk);
        bus.rx_dout = 8'h01; bus.rx_rd = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.run !== 1'b0) begin n_fail++; $display("FAIL run_clear_on_load: got %b expected 0", bus.run); end
        @(negedge clk);
        bus.rx_rd = 1'b0;
        p = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hA1 || ia_q.size() !== 0 || da_q.size() !== 0) begin
            n_fail++; $display("FAIL len0: got %h writes=%0d expected a1 writes=0", st, ia_q.size() + da_q.size());
        end
        send_byte(8'h04);
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hA4 || bus.run !== 1'b0) begin
            n_fail++; $display("FAIL halt: got %h run=%b expected a4 run=0", st, bus.run);
        end
    endtask

    task automatic test_timeout();
        bq_t p;
        logic [7:0] st, est; bit ok;
        clear_mon();
        p = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
        for (int b = 0; b < 5; b++) p.push_back(8'($urandom));
        model(p, est);
        send_pkt(p);
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== est) begin n_fail++; $display("FAIL timeout_ack: got %h expected %h", st, est); end
        n_checks++;
        if (ia_q.size() !== 1 || eia_q.size() !== 1) begin
            n_fail++; $display("FAIL timeout_writes: got %0d expected 1", ia_q.size());
        end else if (ia_q[0] !== eia_q[0] || id_q[0] !== eid_q[0]) begin
            n_fail++; $display("FAIL timeout_word: got %h/%h expected %h/%h", ia_q[0], id_q[0], eia_q[0], eid_q[0]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", bus.busy); end
        send_byte(8'h55);
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hEE) begin n_fail++; $display("FAIL bad_cmd: got %h expected ee", st); end
    endtask

    task automatic test_tx_backpressure();
        logic [7:0] st; bit ok;
        clear_mon();
        bus.tx_ready = 1'b0;
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (50) @(negedge clk);
        n_checks++;
        if (tx_q.size() !== 0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL tx_stall: got pulses=%0d busy=%b expected 0/1", tx_q.size(), bus.busy);
        end
        bus.tx_ready = 1'b1;
        wait_ack(st, ok);
        n_checks++;
        if (!ok || st !== 8'hA4) begin n_fail++; $display("FAIL tx_release: got %h expected a4", st); end
        repeat (10) @(negedge clk);
        n_checks++;
        if (tx_q.size() !== 0 || bus.busy !== 1'b0 || ia_q.size() + da_q.size() !== 0) begin
            n_fail++; $display("FAIL tx_single: got extra=%0d busy=%b expected 0/0", tx_q.size(), bus.busy);
        end
    endtask

    task automatic test_long_strobe();
        clear_mon();
        @(negedge clk);
        bus.rx_dout = 8'h77; bus.rx_rd = 1'b1;
        repeat (20) @(negedge clk);
        bus.rx_rd = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (tx_q.size() !== 1) begin n_fail++; $display("FAIL long_strobe_count: got %0d expected 1", tx_q.size()); end
        else begin
            n_checks++;
            if (tx_q[0] !== 8'hEE) begin n_fail++; $display("FAIL long_strobe_ack: got %h expected ee", tx_q[0]); end
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL long_strobe_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_payload();
        bq_t p;
        clear_mon();
        p = '{8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(p);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.tx_wr, bus.tx_din, bus.insn_addr, bus.insn_din, bus.insn_we, bus.data_addr,
             bus.data_din, bus.data_we, bus.run, bus.busy} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got nonzero outputs expected all 0");
        end
        send_byte(8'hDD);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (ia_q.size() + da_q.size() !== 0 || tx_q.size() !== 0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_quiet: got writes=%0d acks=%0d busy=%b expected 0/0/0",
                               ia_q.size() + da_q.size(), tx_q.size(), bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_insn_load();
        test_data_load();
        test_random_loads();
        test_run_halt();
        test_timeout();
        test_tx_backpressure();
        test_long_strobe();
        test_reset_mid_payload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_loader_ctrl.md
Name: uart_loader_ctrl

Overview:
Framed-command loader and run sequencer between the UART receive/transmit pair and the core's program-load and run inputs. It replaces switch-driven loading. Host bytes are parsed into commands that do three things: write word streams into instruction or data memory, start the core after a settle delay, or halt it. Each command is answered with one status byte on the UART transmit side.

Parameters:
RUN_DELAY, 100, cycles between accepting a RUN command and asserting run
TIMEOUT_CYCLES, 10000000, maximum idle cycles between bytes inside a packet before it is aborted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
rx_rd  in  1  uart_rx byte strobe (level, may span cycles); a rising edge means rx_dout is valid
rx_dout  in  8  received byte
tx_ready  in  1  uart_tx can accept a byte
tx_wr  out  1  one-cycle transmit kick
tx_din  out  32  transmit data; status byte in [7:0], [31:8]=0
insn_addr  out  32  instruction memory byte address
insn_din  out  32  instruction word
insn_we  out  1  instruction write strobe, one cycle per word
data_addr  out  32  data memory byte address
data_din  out  32  data word
data_we  out  1  data write strobe, one cycle per word
run  out  1  core run enable
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: every output is 0, state=IDLE, and all counters and buffers are 0.
- Byte acceptance: a byte is accepted when the registered rx_rd was 0 and the current rx_rd is 1. At most one byte is accepted per edge.
- Packet format:
  - CMD byte first.
  - For CMD 0x01 (insn) and 0x02 (data): ADDR as 4 bytes, little-endian; then LEN as 2 bytes, little-endian, giving a word count; then LEN*4 payload bytes, little-endian per word.
  - CMD 0x03 = RUN. CMD 0x04 = HALT. These carry no further bytes.
- States: IDLE, ADDR, LEN, PAYLOAD, RUNWAIT, ACK.
- IDLE transitions:
  - 0x01 or 0x02: latch the target, clear run on the same edge (run=0 the next cycle), go to ADDR.
  - 0x03: go to RUNWAIT.
  - 0x04: clear run, go to ACK with status 0xA4.
  - Any other value: go to ACK with status 0xEE.
- ADDR: after the 4th byte, base = {addr[31:2], 2'b00}; go to LEN.
- LEN:
  - After the 2nd byte, if LEN=0, go to ACK with status 0xA0|CMD.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Shift each byte into a word as {byte, buf[31:8]}.
  - On the 4th byte of each word, on the next cycle: the selected we=1 for exactly one cycle, addr = base + 4*k (k = word index from 0), din = the assembled word. The other memory's we stays 0.
  - After word LEN-1 is written, go to ACK with status 0xA0|CMD.
  - The address adds modulo 2^32 and wraps silently.
- RUNWAIT:
  - Count RUN_DELAY cycles, then set run=1 and go to ACK with status 0xA3.
  - If run is already 1, skip the wait; status is still 0xA3.
- ACK:
  - Hold until tx_ready=1, then pulse tx_wr for one cycle with tx_din = status, and go to IDLE.
  - Bytes accepted while in ACK or RUNWAIT are discarded.
- Timeout:
  - Applies in ADDR, LEN and PAYLOAD. A counter is reset on every accepted byte.
  - Reaching TIMEOUT_CYCLES aborts the packet and goes to ACK with status 0xEE.
  - Words already written stay written. No partial word is written.
- Write strobes are never asserted outside PAYLOAD.
- run changes only in the cases above: cleared by a write CMD or HALT, set by RUNWAIT completion.
- Reset asserted mid-packet: immediate return to reset values. A partial word is never written.
- busy = (state != IDLE).

Test Plan:
- Reset, then 01 00 01 00 00 02 00 EF BE AD DE 78 56 34 12 -> insn_we pulses twice: addr 0x00000100 din 0xDEADBEEF, then addr 0x00000104 din 0x12345678. data_we stays 0. Then tx_din=0xA1 with one tx_wr pulse.
- 02 03 00 00 00 01 00 11 22 33 44 -> data_addr=0x00000000 (low bits masked), data_din=0x44332211. Ack 0xA2.
- 03 -> run rises exactly RUN_DELAY cycles after the accepted edge, then ack 0xA3. Next 01 00 00 00 00 00 00 -> run=0 the cycle after CMD, no we pulses, ack 0xA1. Then 04 -> ack 0xA4.
- 01, 4 address bytes, LEN=2, 5 payload bytes, then silence TIMEOUT_CYCLES -> exactly one insn_we, ack 0xEE, busy=0 afterwards. CMD 0x55 -> ack 0xEE.
- tx_ready held 0 for 50 cycles in ACK -> tx_wr=0 throughout. Extra rx bytes are ignored. tx_wr pulses once when tx_ready=1.
- rx_rd held high 20 cycles -> one byte accepted. Reset asserted mid-PAYLOAD -> all outputs 0 at once, no write strobe.
